// File: rtl/fetch_pkg.sv
// Shared types, constants and helpers for the instruction-fetch stage.
// FETCH_PERF_EN (see fetch_stage) enables the saturating performance counters.
package fetch_pkg;

    localparam int unsigned DEF_BITS       = 32;
    localparam int unsigned DEF_INSTR_BITS = 32;
    localparam int unsigned DEF_PC_STEP    = 4;

    localparam logic [31:0] NOP = 32'h0000_0000;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        REQ   = ST_REQ,
        HOLD  = ST_HOLD,
        DRAIN = ST_DRAIN
    } fetch_state_e;

    typedef struct packed {
        logic [DEF_INSTR_BITS-1:0] instr;
        logic [DEF_BITS-1:0]       pc;
        logic                      valid;
    } if_id_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: clear (flush) beats load, load beats bubble, otherwise hold.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int unsigned BITS       = DEF_BITS,
    parameter int unsigned INSTR_BITS = DEF_INSTR_BITS
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  load,
    input  logic                  clear,
    input  logic                  bubble,
    input  logic [INSTR_BITS-1:0] instrIn,
    input  logic [BITS-1:0]       pcIn,
    output logic [INSTR_BITS-1:0] instrOut,
    output logic [BITS-1:0]       pcOut,
    output logic                  validOut
);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            instrOut <= INSTR_BITS'(NOP);
            pcOut    <= '0;
            validOut <= 1'b0;
        end else if (clear) begin
            instrOut <= INSTR_BITS'(NOP);
            pcOut    <= '0;
            validOut <= 1'b0;
        end else if (load) begin
            instrOut <= instrIn;
            pcOut    <= pcIn;
            validOut <= 1'b1;
        end else if (bubble) begin
            validOut <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: req/ack to instruction memory, one-entry stall buffer, branch flush.
// Define FETCH_PERF_EN to enable the fetch/bubble performance counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned BITS       = DEF_BITS,
    parameter int unsigned INSTR_BITS = DEF_INSTR_BITS,
    parameter int unsigned PC_STEP    = DEF_PC_STEP
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [BITS-1:0]       pcIn,
    output logic [BITS-1:0]       pcPlusStep,
    output logic                  pcStall,
    output logic                  imemReq,
    output logic [BITS-1:0]       imemAddr,
    input  logic                  imemAck,
    input  logic [INSTR_BITS-1:0] imemData,
    input  logic                  stallIn,
    input  logic                  flush,
    output logic [INSTR_BITS-1:0] instrOut,
    output logic [BITS-1:0]       pcOutId,
    output logic                  validOut,
    output logic [31:0]           fetchCount,
    output logic [31:0]           bubbleCount
);

    fetch_state_e          state, next_state;
    logic [BITS-1:0]       addrReg;
    logic [INSTR_BITS-1:0] bufInstr;
    logic [BITS-1:0]       bufPc;
    logic                  bufLoad;
    logic                  ifLoad, ifClear, ifBubble;
    logic [INSTR_BITS-1:0] ifInstr;
    logic [BITS-1:0]       ifPc;

    assign pcPlusStep = pcIn + BITS'(PC_STEP);
    assign imemReq    = (state == REQ) || (state == DRAIN);
    // DRAIN replays the captured address so it stays stable while the PC moves to the target
    assign imemAddr   = (state == REQ) ? pcIn : addrReg;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            addrReg  <= '0;
            bufInstr <= '0;
            bufPc    <= '0;
        end else begin
            state <= next_state;
            if (state == REQ) begin
                addrReg <= pcIn;
            end
            if (bufLoad) begin
                bufInstr <= imemData;
                bufPc    <= pcIn;
            end
        end
    end

    always_comb begin
        next_state = state;
        pcStall    = 1'b1;
        bufLoad    = 1'b0;
        ifLoad     = 1'b0;
        ifClear    = 1'b0;
        ifBubble   = 1'b0;
        ifInstr    = imemData;
        ifPc       = pcIn;
        case (state)
            IDLE: next_state = REQ;
            REQ: begin
                if (flush) begin
                    ifClear = 1'b1;
                    pcStall = 1'b0;
                    if (!imemAck) next_state = DRAIN;
                end else if (imemAck) begin
                    pcStall = 1'b0;
                    if (stallIn) begin
                        bufLoad    = 1'b1;
                        next_state = HOLD;
                    end else begin
                        ifLoad = 1'b1;
                    end
                end else if (!stallIn) begin
                    ifBubble = 1'b1;
                end
            end
            HOLD: begin
                if (flush) begin
                    ifClear    = 1'b1;
                    pcStall    = 1'b0;
                    next_state = REQ;
                end else if (!stallIn) begin
                    ifLoad     = 1'b1;
                    ifInstr    = bufInstr;
                    ifPc       = bufPc;
                    next_state = REQ;
                end
            end
            DRAIN: begin
                if (flush) begin
                    ifClear = 1'b1;
                    pcStall = 1'b0;
                end else if (imemAck) begin
                    next_state = REQ;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    if_id_reg #(
        .BITS       (BITS),
        .INSTR_BITS (INSTR_BITS)
    ) u_if_id (
        .CLK      (CLK),
        .RESET    (RESET),
        .load     (ifLoad),
        .clear    (ifClear),
        .bubble   (ifBubble),
        .instrIn  (ifInstr),
        .pcIn     (ifPc),
        .instrOut (instrOut),
        .pcOut    (pcOutId),
        .validOut (validOut)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] fetchCnt, bubbleCnt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            fetchCnt  <= '0;
            bubbleCnt <= '0;
        end else begin
            if (ifLoad && !ifClear) fetchCnt <= sat_inc(fetchCnt);
            if (ifClear || ifBubble) bubbleCnt <= sat_inc(bubbleCnt);
        end
    end

    assign fetchCount  = fetchCnt;
    assign bubbleCount = bubbleCnt;
`else
    assign fetchCount  = '0;
    assign bubbleCount = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; counter expectations follow FETCH_PERF_EN.
`timescale 1ns/1ps
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] pcIn = '0;
    logic [31:0] pcPlusStep;
    logic        pcStall;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck = 1'b0;
    logic [31:0] imemData = '0;
    logic        stallIn = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] instrOut;
    logic [31:0] pcOutId;
    logic        validOut;
    logic [31:0] fetchCount;
    logic [31:0] bubbleCount;

    int checks = 0;
    int errors = 0;

`ifdef FETCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    fetch_stage dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .pcIn        (pcIn),
        .pcPlusStep  (pcPlusStep),
        .pcStall     (pcStall),
        .imemReq     (imemReq),
        .imemAddr    (imemAddr),
        .imemAck     (imemAck),
        .imemData    (imemData),
        .stallIn     (stallIn),
        .flush       (flush),
        .instrOut    (instrOut),
        .pcOutId     (pcOutId),
        .validOut    (validOut),
        .fetchCount  (fetchCount),
        .bubbleCount (bubbleCount)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        pcIn = 32'h1234; imemAck = 1'b1; imemData = 32'hDEAD_BEEF; stallIn = 1'b1; flush = 1'b1;
        tick(); tick();
        checks++; if (instrOut !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 00000000", instrOut); end
        checks++; if (pcOutId !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 00000000", pcOutId); end
        checks++; if (validOut !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", validOut); end
        checks++; if (imemReq !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imemReq); end
        checks++; if (pcStall !== 1'b1) begin errors++; $display("FAIL reset_stall: got %b expected 1", pcStall); end
        checks++; if (fetchCount !== 32'h0 || bubbleCount !== 32'h0) begin errors++; $display("FAIL reset_cnt: got %h/%h expected 0/0", fetchCount, bubbleCount); end
        pcIn = 32'h0; imemAck = 1'b0; imemData = 32'h0; stallIn = 1'b0; flush = 1'b0;
        RESET = 1'b0;
        #1;
        checks++; if (imemReq !== 1'b0) begin errors++; $display("FAIL idle_req: got %b expected 0", imemReq); end
        tick();
        checks++; if (imemReq !== 1'b1) begin errors++; $display("FAIL first_req: got %b expected 1", imemReq); end
        checks++; if (imemAddr !== 32'h0) begin errors++; $display("FAIL first_addr: got %h expected 00000000", imemAddr); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pcs [3];
        logic [31:0] dat [3];
        pcs = '{32'h0, 32'h4, 32'h8};
        dat = '{32'h11, 32'h22, 32'h33};
        for (int i = 0; i < 3; i++) begin
            pcIn = pcs[i]; imemAck = 1'b1; imemData = dat[i];
            #1;
            checks++; if (pcStall !== 1'b0) begin errors++; $display("FAIL b2b_stall[%0d]: got %b expected 0", i, pcStall); end
            checks++; if (pcPlusStep !== pcs[i] + 32'd4) begin errors++; $display("FAIL b2b_plus[%0d]: got %h expected %h", i, pcPlusStep, pcs[i] + 32'd4); end
            tick();
            checks++; if (instrOut !== dat[i] || pcOutId !== pcs[i] || validOut !== 1'b1) begin
                errors++; $display("FAIL b2b_ifid[%0d]: got %h/%h/%b expected %h/%h/1", i, instrOut, pcOutId, validOut, dat[i], pcs[i]);
            end
        end
    endtask

    task automatic test_flush_pending();
        pcIn = 32'h20; imemAck = 1'b0; flush = 1'b1;
        #1;
        checks++; if (pcStall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b expected 0", pcStall); end
        checks++; if (imemAddr !== 32'h20) begin errors++; $display("FAIL flush_addr: got %h expected 00000020", imemAddr); end
        tick();
        flush = 1'b0; pcIn = 32'h100;
        #1;
        checks++; if (validOut !== 1'b0 || instrOut !== 32'h0) begin errors++; $display("FAIL flush_ifid: got %h/%b expected 00000000/0", instrOut, validOut); end
        checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h20) begin errors++; $display("FAIL drain_addr: got %b/%h expected 1/00000020", imemReq, imemAddr); end
        checks++; if (pcStall !== 1'b1) begin errors++; $display("FAIL drain_stall: got %b expected 1", pcStall); end
        checks++; if (fetchCount !== (PERF ? 32'd3 : 32'd0)) begin errors++; $display("FAIL perf_fetch: got %0d expected %0d", fetchCount, PERF ? 3 : 0); end
        checks++; if (bubbleCount !== (PERF ? 32'd1 : 32'd0)) begin errors++; $display("FAIL perf_bubble: got %0d expected %0d", bubbleCount, PERF ? 1 : 0); end
        tick();
        checks++; if (imemAddr !== 32'h20) begin errors++; $display("FAIL drain_wait_addr: got %h expected 00000020", imemAddr); end
        imemAck = 1'b1; imemData = 32'hEE;
        #1;
        checks++; if (pcStall !== 1'b1) begin errors++; $display("FAIL drain_ack_stall: got %b expected 1", pcStall); end
        tick();
        imemAck = 1'b0;
        #1;
        checks++; if (instrOut !== 32'h0 || validOut !== 1'b0) begin errors++; $display("FAIL drain_discard: got %h/%b expected 00000000/0", instrOut, validOut); end
        checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h100) begin errors++; $display("FAIL post_drain_addr: got %b/%h expected 1/00000100", imemReq, imemAddr); end
    endtask

    task automatic test_delayed_ack();
        pcIn = 32'h40; imemAck = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (pcStall !== 1'b1 || imemAddr !== 32'h40) begin errors++; $display("FAIL wait_hold[%0d]: got %b/%h expected 1/00000040", i, pcStall, imemAddr); end
            tick();
            checks++; if (validOut !== 1'b0) begin errors++; $display("FAIL wait_valid[%0d]: got %b expected 0", i, validOut); end
        end
        imemAck = 1'b1; imemData = 32'hAB;
        tick();
        imemAck = 1'b0;
        checks++; if (instrOut !== 32'hAB || pcOutId !== 32'h40 || validOut !== 1'b1) begin
            errors++; $display("FAIL delayed_ifid: got %h/%h/%b expected 000000ab/00000040/1", instrOut, pcOutId, validOut);
        end
    endtask

    task automatic test_stall_hold();
        pcIn = 32'h10; stallIn = 1'b1; imemAck = 1'b1; imemData = 32'hCD;
        #1;
        checks++; if (pcStall !== 1'b0) begin errors++; $display("FAIL stall_ack_pcstall: got %b expected 0", pcStall); end
        tick();
        imemAck = 1'b0; pcIn = 32'h14;
        #1;
        checks++; if (imemReq !== 1'b0 || pcStall !== 1'b1) begin errors++; $display("FAIL hold_outputs: got %b/%b expected 0/1", imemReq, pcStall); end
        checks++; if (instrOut !== 32'hAB || pcOutId !== 32'h40 || validOut !== 1'b1) begin
            errors++; $display("FAIL hold_ifid: got %h/%h/%b expected 000000ab/00000040/1", instrOut, pcOutId, validOut);
        end
        tick();
        stallIn = 1'b0;
        tick();
        checks++; if (instrOut !== 32'hCD || pcOutId !== 32'h10 || validOut !== 1'b1) begin
            errors++; $display("FAIL release_ifid: got %h/%h/%b expected 000000cd/00000010/1", instrOut, pcOutId, validOut);
        end
        checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h14) begin errors++; $display("FAIL release_req: got %b/%h expected 1/00000014", imemReq, imemAddr); end
    endtask

    task automatic test_flush_with_ack();
        pcIn = 32'h200; imemAck = 1'b1; imemData = 32'h77; flush = 1'b1;
        #1;
        checks++; if (pcStall !== 1'b0) begin errors++; $display("FAIL flushack_stall: got %b expected 0", pcStall); end
        tick();
        imemAck = 1'b0; flush = 1'b0; pcIn = 32'h300;
        #1;
        checks++; if (imemAddr !== 32'h300) begin errors++; $display("FAIL flushack_state: got %h expected 00000300", imemAddr); end
        checks++; if (instrOut !== 32'h0 || validOut !== 1'b0) begin errors++; $display("FAIL flushack_drop: got %h/%b expected 00000000/0", instrOut, validOut); end
    endtask

    task automatic test_flush_hold();
        pcIn = 32'h50; stallIn = 1'b1; imemAck = 1'b1; imemData = 32'h99;
        tick();
        imemAck = 1'b0; flush = 1'b1;
        #1;
        checks++; if (pcStall !== 1'b0) begin errors++; $display("FAIL flushhold_stall: got %b expected 0", pcStall); end
        tick();
        flush = 1'b0; stallIn = 1'b0; pcIn = 32'h60;
        #1;
        checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h60) begin errors++; $display("FAIL flushhold_req: got %b/%h expected 1/00000060", imemReq, imemAddr); end
        tick();
        checks++; if (instrOut === 32'h99 || validOut !== 1'b0) begin errors++; $display("FAIL flushhold_discard: got %h/%b expected not 00000099/0", instrOut, validOut); end
    endtask

    task automatic test_wrap();
        pcIn = 32'hFFFF_FFFC;
        #1;
        checks++; if (pcPlusStep !== 32'h0) begin errors++; $display("FAIL wrap: got %h expected 00000000", pcPlusStep); end
        pcIn = 32'h7FFF_FFFC;
        #1;
        checks++; if (pcPlusStep !== 32'h8000_0000) begin errors++; $display("FAIL carry: got %h expected 80000000", pcPlusStep); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_flush_pending();
        test_delayed_ack();
        test_stall_hold();
        test_flush_with_ack();
        test_flush_hold();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Takes the current PC and runs a req/ack handshake to instruction memory; memory latency is variable.
- Captures the returned instruction into the IF/ID pipeline register, produces PC+step for the next-PC mux, and drives the stall input of the PC register.
- Handles downstream stall (one-entry hold buffer) and branch flush, including an in-flight request that cannot be aborted.

Parameters:
- BITS, 32, PC/address width
- INSTR_BITS, 32, instruction width
- PC_STEP, 4, PC increment per fetched instruction

Ports:
- CLK  input  1  clock, rising edge
- RESET  input  1  asynchronous, active-high reset
- pcIn  input  BITS  current PC from PC register
- pcPlusStep  output  BITS  pcIn+PC_STEP, to next-PC mux
- pcStall  output  1  hold PC register (1 = hold)
- imemReq  output  1  instruction memory request
- imemAddr  output  BITS  request address, stable while imemReq=1
- imemAck  input  1  data valid, single-cycle pulse
- imemData  input  INSTR_BITS  instruction returned with imemAck
- stallIn  input  1  ID stage cannot accept (hazard unit)
- flush  input  1  taken branch; squash fetch
- instrOut  output  INSTR_BITS  IF/ID instruction
- pcOutId  output  BITS  IF/ID PC of instrOut
- validOut  output  1  IF/ID valid
- fetchCount  output  32  perf counter (see Optional Feature)
- bubbleCount  output  32  perf counter (see Optional Feature)

Behaviour:
- Reset (async, immediate):
  - state=IDLE; imemReq=0; instrOut=NOP (all zeros); pcOutId=0; validOut=0; addrReg=0; hold buffer cleared; counters=0.
- States: IDLE, REQ, HOLD, DRAIN.
- IDLE: imemReq=0, pcStall=1. Moves unconditionally to REQ on the first clock after RESET deasserts.
- REQ:
  - Outputs: imemReq=1, imemAddr=pcIn. addrReg<=pcIn every cycle.
  - ack & !stallIn: IF/ID <= {imemData, pcIn, valid=1}; pcStall=0 this cycle, so the PC advances at the same edge; stay REQ. This gives back-to-back fetch with single-cycle ack.
  - ack & stallIn: hold buffer <= {imemData, pcIn}; IF/ID unchanged; pcStall=0; go HOLD.
  - !ack & !stallIn: validOut<=0 (bubble); pcStall=1.
  - !ack & stallIn: IF/ID holds; pcStall=1.
- HOLD:
  - Outputs: imemReq=0, pcStall=1.
  - When stallIn=0: IF/ID <= buffer with valid=1; go REQ.
- DRAIN:
  - Outputs: imemReq=1, imemAddr=addrReg (old address), pcStall=1.
  - On ack: data discarded; go REQ.
- flush (highest priority, overrides stallIn):
  - IF/ID <= {NOP, 0, valid=0}; pcStall=0 so the PC loads the branch target.
  - In REQ with no ack in the same cycle: go DRAIN, since the outstanding request must complete.
  - In REQ with ack in the same cycle: data dropped; stay REQ.
  - In HOLD: buffer discarded; go REQ.
  - In DRAIN: stay DRAIN.
  - In IDLE: no effect.
- imemAddr is stable for the whole time imemReq=1. pcStall guarantees this in REQ; addrReg guarantees it in DRAIN.
- pcPlusStep: combinational pcIn+PC_STEP, truncated to BITS (wraps, e.g. FFFFFFFC+4=0).
- pcStall is combinational from state, imemAck, stallIn and flush. In REQ it is 1 whenever no ack and no flush.
- Latency:
  - Ack in the cycle after the request is presented → instrOut valid on the next edge.
  - Throughput: 1 instruction per cycle when memory acks every cycle.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined:
  - fetchCount increments on every IF/ID load with valid=1.
  - bubbleCount increments on every edge where validOut is written to 0 (bubble or flush).
  - Both 32-bit, saturate at FFFFFFFF, reset to 0.
- Undefined: no counter logic; both ports tied to 0. The port list is unchanged either way.

Decomposition:
- Package fetch_pkg:
  - state enum typedef (IDLE, REQ, HOLD, DRAIN)
  - NOP constant (32'h0)
  - default PC_STEP
  - IF/ID payload struct {instr, pc, valid}
- Sub-module if_id_reg:
  - IF/ID register with load/flush/hold controls and async RESET.
  - fetch_stage instantiates it for instrOut/pcOutId/validOut.

Test Plan:
1. RESET high with activity on inputs → all outputs zero, imemReq=0. Release RESET, pcIn=0 → next cycle imemReq=1, imemAddr=0.
2. Memory acks every cycle; instructions 0x11,0x22,0x33 at pcIn 0,4,8 → instrOut/pcOutId = 0x11/0, 0x22/4, 0x33/8 on consecutive cycles; pcStall=0 throughout; pcPlusStep=pcIn+4.
3. Ack delayed 3 cycles at pcIn=0x40 → pcStall=1 and imemAddr=0x40 held for 3 cycles; validOut=0 during the wait; ack data 0xAB lands with pcOutId=0x40.
4. stallIn=1 when ack 0xCD arrives at pcIn=0x10 → state HOLD, imemReq=0, IF/ID unchanged. stallIn drops 2 cycles later → instrOut=0xCD, pcOutId=0x10, validOut=1.
5. flush while request to 0x20 is pending (no ack) → validOut=0, pcStall=0 for 1 cycle, state DRAIN with imemAddr=0x20. Ack with 0xEE is discarded; next request uses the new pcIn=0x100.
6. pcIn=0xFFFFFFFC → pcPlusStep=0x0. With FETCH_PERF_EN, scenario 2 then a flush → fetchCount=3, bubbleCount=1.
